// File: rtl/conv_pixel_engine.sv
// conv_pixel_engine
// Computes one output pixel for NUM_CH output channels at once. Operand beats
// (one shared activation, one weight per channel) are accumulated per channel.
// The sum then has bias added, goes through LeakyReLU, and is requantized to
// int8 with round-half-up and saturation.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on start
// ACCUM | accepting operand beats, acc[c] += w[c] * activation
// BIAS  | acc[c] += bias[c]
// ACT   | acc[c] = LeakyReLU(acc[c])
// REQ   | requantize and saturate acc[c] into out_data
// OUT   | out_valid held until out_ready
module conv_pixel_engine #(
    parameter int NUM_CH      = 4,
    parameter int MAX_MACS    = 576,
    parameter int SCALE_Q     = 16,
    parameter int LEAKY_SHIFT = 3,
    localparam int CNT_W      = $clog2(MAX_MACS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_macs,
    input  logic [NUM_CH*32-1:0]   bias,
    input  logic [15:0]            scale,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             activation,
    input  logic [NUM_CH*8-1:0]    weights,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*8-1:0]    out_data,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_ACT,
        S_REQ,
        S_OUT
    } state_t;

    localparam logic signed [48:0] RND     = 49'sd1 <<< (SCALE_Q - 1);
    localparam logic signed [48:0] SAT_MAX = 49'sd127;
    localparam logic signed [48:0] SAT_MIN = -49'sd128;

    state_t state, state_nxt;

    logic [CNT_W-1:0]        beats_left;
    logic [CNT_W-1:0]        num_clamped;
    logic [NUM_CH*32-1:0]    bias_q;
    logic [15:0]             scale_q;
    logic                    job_start;
    logic                    beat_take;
    logic                    last_beat;

    // acc holds the running MAC sum, then the biased sum, then the activated value
    logic signed [31:0]      acc    [NUM_CH];
    logic signed [15:0]      prod   [NUM_CH];
    logic signed [31:0]      leaky  [NUM_CH];
    logic signed [48:0]      scaled [NUM_CH];
    logic signed [48:0]      q      [NUM_CH];
    logic [7:0]              sat    [NUM_CH];

    assign num_clamped = (num_macs > CNT_W'(MAX_MACS)) ? CNT_W'(MAX_MACS) : num_macs;
    assign job_start   = (state == S_IDLE) && start;
    assign beat_take   = in_valid && in_ready;
    assign last_beat   = beat_take && (beats_left == CNT_W'(1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode; handshake outputs are pure state decodes
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_clamped == '0) ? S_BIAS : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = S_BIAS;
                end
            end
            S_BIAS:  state_nxt = S_ACT;
            S_ACT:   state_nxt = S_REQ;
            S_REQ:   state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // job parameters and remaining-beat down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
            bias_q     <= '0;
            scale_q    <= '0;
        end else if (job_start) begin
            beats_left <= num_clamped;
            bias_q     <= bias;
            scale_q    <= scale;
        end else if (beat_take) begin
            beats_left <= beats_left - CNT_W'(1);
        end
    end

    // per-channel product, LeakyReLU and requantization arithmetic
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]   = $signed({{8{weights[c*8+7]}}, weights[c*8 +: 8]})
                      * $signed({{8{activation[7]}}, activation});
            leaky[c]  = acc[c][31] ? (acc[c] >>> LEAKY_SHIFT) : acc[c];
            scaled[c] = $signed({{17{acc[c][31]}}, acc[c]}) * $signed({33'd0, scale_q}) + RND;
            q[c]      = scaled[c] >>> SCALE_Q;
            if (q[c] > SAT_MAX) begin
                sat[c] = 8'h7F;
            end else if (q[c] < SAT_MIN) begin
                sat[c] = 8'h80;
            end else begin
                sat[c] = q[c][7:0];
            end
        end
    end

    // accumulator pipeline: clear at start, MAC, bias, activation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (state)
                    S_IDLE:  if (start) acc[c] <= '0;
                    S_ACCUM: if (beat_take) acc[c] <= acc[c] + {{16{prod[c][15]}}, prod[c]};
                    S_BIAS:  acc[c] <= acc[c] + $signed(bias_q[c*32 +: 32]);
                    S_ACT:   acc[c] <= leaky[c];
                    default: acc[c] <= acc[c];
                endcase
            end
        end
    end

    // result register, loaded once per job and kept until the next REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (state == S_REQ) begin
            for (int c = 0; c < NUM_CH; c++) begin
                out_data[c*8 +: 8] <= sat[c];
            end
        end
    end

endmodule
